logic2048_line_seq: RTL and testbench

//  Sequential, parametrised 2048 line engine. Slides and merges one line of N_CELLS tiles toward

---
 rtl/logic2048_line_seq.sv | 154 +++++++++++++++
 tb/tb_logic2048_line_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/logic2048_line_seq.sv
// logic2048_line_seq: sequential 2048 line slide/merge engine, one cell per clock
module logic2048_line_seq #(
    parameter int N_CELLS = 4,
    parameter int CELL_W  = 4,
    parameter int SCORE_W = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 dir,
    input  logic [N_CELLS*CELL_W-1:0]            line_in,
    output logic                                 busy,
    output logic                                 done,
    output logic [N_CELLS*CELL_W-1:0]            line_out,
    output logic                                 moved,
    output logic [SCORE_W-1:0]                   score_add,
    output logic [$clog2(N_CELLS/2+1)-1:0]       merge_cnt
);
    localparam int AW = $clog2(N_CELLS);
    localparam int IW = AW + 1;
    localparam int MW = $clog2(N_CELLS/2+1);
    typedef logic [N_CELLS-1:0][CELL_W-1:0] line_t;
    typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;
    state_t state_q, state_d;
    line_t cap_q, cap_d, buf_q, buf_d, lo_q, lo_d;
    logic dir_q, dir_d, pv_q, pv_d, busy_q, busy_d, done_q, done_d, mv_q, mv_d;
    logic [CELL_W-1:0] p_q, p_d, c;
    logic [AW-1:0] k_q, k_d, idx;
    logic [IW-1:0] wp_q, wp_d, wp_step;
    logic [SCORE_W-1:0] acc_q, acc_d, sa_q, sa_d, pow;
    logic [SCORE_W:0] sum;
    logic [MW-1:0] mc_q, mc_d, mo_q, mo_d;
    int e;
    assign idx      = dir_q ? AW'(N_CELLS-1) - k_q : k_q;
    assign c        = cap_q[idx];
    assign wp_step  = dir_q ? wp_q - 1'b1 : wp_q + 1'b1;
    assign busy     = busy_q;
    assign done     = done_q;
    assign line_out = lo_q;
    assign moved    = mv_q;
    assign score_add = sa_q;
    assign merge_cnt = mo_q;
    // state register
    always_ff @(posedge clk)
        state_q <= rst ? IDLE : state_d;
    // next state: one scan cycle per cell, then flush and result
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? SCAN : IDLE;
            SCAN:    state_d = (k_q == AW'(N_CELLS-1)) ? FLUSH : SCAN;
            FLUSH:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end
    // datapath: pending-tile merge into the work buffer, outputs published on done
    always_comb begin
        cap_d  = cap_q;
        buf_d  = buf_q;
        lo_d   = lo_q;
        dir_d  = dir_q;
        pv_d   = pv_q;
        p_d    = p_q;
        k_d    = k_q;
        wp_d   = wp_q;
        acc_d  = acc_q;
        mc_d   = mc_q;
        busy_d = busy_q;
        done_d = 1'b0;
        mv_d   = mv_q;
        sa_d   = sa_q;
        mo_d   = mo_q;
        e      = int'(c) + 1;
        pow    = (e >= SCORE_W) ? '1 : SCORE_W'(1) << e;
        sum    = {1'b0, acc_q} + {1'b0, pow};
        case (state_q)
            IDLE: if (start) begin
                cap_d  = line_in;
                dir_d  = dir;
                buf_d  = '0;
                wp_d   = dir ? IW'(N_CELLS-1) : '0;
                pv_d   = 1'b0;
                k_d    = '0;
                acc_d  = '0;
                mc_d   = '0;
                busy_d = 1'b1;
            end
            SCAN: begin
                k_d = k_q + 1'b1;
                if (c != '0) begin
                    if (pv_q && p_q == c && c != '1) begin
                        buf_d[wp_q[AW-1:0]] = c + 1'b1;
                        wp_d  = wp_step;
                        pv_d  = 1'b0;
                        mc_d  = mc_q + 1'b1;
                        acc_d = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
                    end else if (pv_q) begin
                        buf_d[wp_q[AW-1:0]] = p_q;
                        wp_d = wp_step;
                        p_d  = c;
                    end else begin
                        p_d  = c;
                        pv_d = 1'b1;
                    end
                end
            end
            FLUSH: if (pv_q) buf_d[wp_q[AW-1:0]] = p_q;
            default: begin
                busy_d = 1'b0;
                done_d = 1'b1;
                lo_d   = buf_q;
                mv_d   = buf_q != cap_q;
                sa_d   = acc_q;
                mo_d   = mc_q;
            end
        endcase
    end
    // datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_q  <= '0;
            buf_q  <= '0;
            lo_q   <= '0;
            dir_q  <= 1'b0;
            pv_q   <= 1'b0;
            p_q    <= '0;
            k_q    <= '0;
            wp_q   <= '0;
            acc_q  <= '0;
            mc_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            mv_q   <= 1'b0;
            sa_q   <= '0;
            mo_q   <= '0;
        end else begin
            cap_q  <= cap_d;
            buf_q  <= buf_d;
            lo_q   <= lo_d;
            dir_q  <= dir_d;
            pv_q   <= pv_d;
            p_q    <= p_d;
            k_q    <= k_d;
            wp_q   <= wp_d;
            acc_q  <= acc_d;
            mc_q   <= mc_d;
            busy_q <= busy_d;
            done_q <= done_d;
            mv_q   <= mv_d;
            sa_q   <= sa_d;
            mo_q   <= mo_d;
        end
    end
endmodule

// File: tb/tb_logic2048_line_seq.sv
// tb_logic2048_line_seq: randomized scoreboard bench for the 2048 line engine
module tb_logic2048_line_seq;
    localparam int N = 4;
    localparam int W = 4;
    localparam int S = 16;
    typedef struct {
        logic [N*W-1:0] line;
        logic           mv;
        logic [S-1:0]   sc;
        logic [1:0]     mc;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic dir = 1'b0;
    logic [N*W-1:0] line_in = '0;
    logic busy, done, moved;
    logic [N*W-1:0] line_out;
    logic [S-1:0] score_add;
    logic [1:0] merge_cnt;
    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int accepted = 0;
    int dones = 0;
    logic [N*W-1:0] prev_out = '0;

    logic2048_line_seq #(.N_CELLS(N), .CELL_W(W), .SCORE_W(S)) dut (
        .clk(clk), .rst(rst), .start(start), .dir(dir), .line_in(line_in),
        .busy(busy), .done(done), .line_out(line_out), .moved(moved),
        .score_add(score_add), .merge_cnt(merge_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, a, x);
        end
    endtask

    function automatic logic [N*W-1:0] pk(input int a, input int b, input int c, input int d);
        logic [N*W-1:0] r;
        r = {W'(d), W'(c), W'(b), W'(a)};
        return r;
    endfunction

    // reference: collect tiles in travel order, pair equal neighbours greedily, repack from the far end
    function automatic exp_t model(input logic d, input logic [N*W-1:0] ln);
        exp_t r;
        int t[$];
        int m[$];
        int i;
        longint sc;
        int v;
        int idx;
        sc = 0;
        r.mc = 0;
        for (int j = 0; j < N; j++) begin
            idx = d ? N-1-j : j;
            v = int'(ln[idx*W +: W]);
            if (v != 0) t.push_back(v);
        end
        i = 0;
        while (i < t.size()) begin
            if (i+1 < t.size() && t[i] == t[i+1] && t[i] != (1<<W)-1) begin
                m.push_back(t[i]+1);
                sc += (t[i]+1 >= S) ? (longint'(1)<<S)-1 : longint'(1) << (t[i]+1);
                r.mc = r.mc + 1'b1;
                i += 2;
            end else begin
                m.push_back(t[i]);
                i += 1;
            end
        end
        r.line = '0;
        for (int j = 0; j < m.size(); j++) begin
            idx = d ? N-1-j : j;
            r.line[idx*W +: W] = W'(m[j]);
        end
        r.mv = r.line != ln;
        r.sc = (sc > (longint'(1)<<S)-1) ? '1 : S'(sc);
        return r;
    endfunction

    // monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done) begin
            dones++;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL spurious_done line_out=%h", line_out);
            end else begin
                exp_t x;
                x = q.pop_front();
                if (line_out !== x.line || moved !== x.mv || score_add !== x.sc || merge_cnt !== x.mc) begin
                    errors++;
                    $display("FAIL result got line=%h mv=%b sc=%0d mc=%0d want line=%h mv=%b sc=%0d mc=%0d",
                             line_out, moved, score_add, merge_cnt, x.line, x.mv, x.sc, x.mc);
                end
            end
        end
    end

    // issue one transaction from a negedge in IDLE; returns at the negedge of its done cycle
    task automatic xact(input logic d, input logic [N*W-1:0] ln);
        start = 1'b1;
        dir = d;
        line_in = ln;
        q.push_back(model(d, ln));
        accepted++;
        @(posedge clk);
        #1;
        start = 1'b0;
        line_in = N*W'($urandom);
        dir = $urandom_range(0, 1);
        for (int j = 0; j <= N+2; j++) begin
            @(negedge clk);
            if (j == 1) begin
                start = 1'b1;
                line_in = N*W'($urandom);
            end
            if (j == 2) start = 1'b0;
            if (j == N+2) begin
                chk("done_high", done, 1'b1);
                chk("busy_low_at_done", busy, 1'b0);
            end else begin
                chk("busy_high", busy, 1'b1);
                chk("done_low", done, 1'b0);
            end
        end
    endtask

    initial begin
        logic [N*W-1:0] ln;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_line", line_out, '0);
        chk("rst_moved", moved, 1'b0);
        chk("rst_score", score_add, '0);
        chk("rst_mcnt", merge_cnt, '0);
        rst = 1'b0;
        @(negedge clk);
        xact(1'b0, pk(0, 1, 2, 0));
        xact(1'b0, pk(1, 1, 2, 0));
        xact(1'b0, pk(1, 1, 1, 1));
        xact(1'b1, pk(1, 1, 1, 0));
        xact(1'b0, pk(1, 2, 3, 4));
        xact(1'b0, pk(15, 15, 0, 0));
        xact(1'b0, pk(0, 0, 0, 0));
        xact(1'b0, pk(14, 14, 14, 14));
        xact(1'b1, pk(2, 0, 2, 3));
        prev_out = line_out;
        chk("prev_nonzero", prev_out != '0, 1'b1);
        start = 1'b1;
        dir = 1'b0;
        line_in = pk(3, 3, 1, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_done", done, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_line", line_out, '0);
        chk("abort_moved", moved, 1'b0);
        chk("abort_score", score_add, '0);
        chk("abort_mcnt", merge_cnt, '0);
        rst = 1'b0;
        repeat (N+4) begin
            @(negedge clk);
            chk("abort_no_done", done, 1'b0);
        end
        xact(1'b0, pk(3, 3, 1, 0));
        for (int n = 0; n < 200; n++) begin
            for (int i = 0; i < N; i++)
                ln[i*W +: W] = n[0] ? W'($urandom_range(0, 3)) : W'($urandom);
            if (n % 5 == 0) begin
                start = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            xact(1'($urandom_range(0, 1)), ln);
        end
        start = 1'b0;
        repeat (N+4) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        chk("done_count", dones, accepted);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
